// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core (priority) and a host requester,
// with a bounded host wait and 1-cycle read-return routing. Optional DMEM_ARB_STATS_EN adds a conflict counter.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c_req,
    input  logic              i_c_wen,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    input  logic              i_h_req,
    input  logic              i_h_wen,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [DATA_W-1:0] i_h_wdata,
    output logic              o_h_gnt,
    output logic              o_h_rvalid,
    output logic [DATA_W-1:0] o_h_rdata,
    output logic              o_d_wen,
    output logic [ADDR_W-1:0] o_d_addr,
    output logic [DATA_W-1:0] o_d_wdata,
    input  logic [DATA_W-1:0] i_d_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       o_conflict_cnt
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(HOST_MAX_WAIT);

    localparam logic [0:0] CORE_PRI   = 1'b0;
    localparam logic [0:0] HOST_FORCE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rvalid_q, rvalid_d;
    logic             owner_q, owner_d;   // 1 = host owns the pending read return
    logic             c_win, h_win;

    // Winner selection; reset forces all grants low asynchronously
    always_comb begin
        c_win = 1'b0;
        h_win = 1'b0;
        if (!i_rst) begin
            case (state_q)
                HOST_FORCE: begin
                    if (i_h_req)      h_win = 1'b1;
                    else if (i_c_req) c_win = 1'b1;
                end
                default: begin
                    if (i_c_req)      c_win = 1'b1;
                    else if (i_h_req) h_win = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        o_d_wen   = 1'b0;
        o_d_addr  = '0;
        o_d_wdata = '0;
        if (c_win) begin
            o_d_wen   = i_c_wen;
            o_d_addr  = i_c_addr;
            o_d_wdata = i_c_wdata;
        end else if (h_win) begin
            o_d_wen   = i_h_wen;
            o_d_addr  = i_h_addr;
            o_d_wdata = i_h_wdata;
        end
    end

    assign o_c_gnt = c_win;
    assign o_h_gnt = h_win;

    // Next-state: wait counter saturates at the limit, force state lasts until the host is served or gives up
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        rvalid_d = (c_win && !i_c_wen) || (h_win && !i_h_wen);
        owner_d  = h_win;
        if (!i_h_req || h_win) begin
            wait_d = '0;
        end else if (wait_q != MAX_WAIT) begin
            wait_d = wait_q + CNT_W'(1);
        end
        case (state_q)
            HOST_FORCE: if (h_win || !i_h_req) state_d = CORE_PRI;
            default:    if (wait_d == MAX_WAIT) state_d = HOST_FORCE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= CORE_PRI;
            wait_q   <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
        end
    end

    assign o_c_rvalid = rvalid_q && !owner_q;
    assign o_h_rvalid = rvalid_q && owner_q;
    assign o_c_rdata  = o_c_rvalid ? i_d_rdata : '0;
    assign o_h_rdata  = o_h_rvalid ? i_d_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_q;

    // Saturating count of cycles where both requesters contend
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conflict_q <= '0;
        end else if (i_c_req && i_h_req && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign o_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a memory model behind the port and a
// scoreboard queue of expected read returns checked one cycle after each grant.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_wen, h_req, h_wen;
    logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
    logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [31:0] c_rdata, h_rdata;
    logic        d_wen;
    logic [31:0] d_addr, d_wdata, d_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        c;
        logic        h;
        logic [31:0] d;
    } ret_t;

    ret_t        expq[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_h_req(h_req), .i_h_wen(h_wen), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
        .o_h_gnt(h_gnt), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
        .o_d_wen(d_wen), .o_d_addr(d_addr), .o_d_wdata(d_wdata), .i_d_rdata(d_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .o_conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, read data one cycle after the address
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (d_wen) mem[d_addr[7:0]] <= d_wdata;
        d_rdata <= mem[d_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                        input logic ec, input logic eh);
        ret_t        r;
        logic        ewen;
        logic [31:0] eaddr, ewd;
        c_req = cr; c_wen = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_wen = hw; h_addr = ha; h_wdata = hd;
        @(negedge clk);
        check("c_gnt", 32'(c_gnt), 32'(ec));
        check("h_gnt", 32'(h_gnt), 32'(eh));
        ewen = 1'b0; eaddr = '0; ewd = '0;
        if (ec) begin ewen = cw; eaddr = ca; ewd = cd; end
        else if (eh) begin ewen = hw; eaddr = ha; ewd = hd; end
        check("d_wen", 32'(d_wen), 32'(ewen));
        check("d_addr", d_addr, eaddr);
        check("d_wdata", d_wdata, ewd);
        r = '{c: 1'b0, h: 1'b0, d: 32'h0};
        if (expq.size() > 0) r = expq.pop_front();
        check("c_rvalid", 32'(c_rvalid), 32'(r.c));
        check("h_rvalid", 32'(h_rvalid), 32'(r.h));
        check("c_rdata", c_rdata, r.c ? r.d : 32'h0);
        check("h_rdata", h_rdata, r.h ? r.d : 32'h0);
        if (ec && !cw)      expq.push_back('{c: 1'b1, h: 1'b0, d: ref_mem[ca[7:0]]});
        else if (eh && !hw) expq.push_back('{c: 1'b0, h: 1'b1, d: ref_mem[ha[7:0]]});
        else                expq.push_back('{c: 1'b0, h: 1'b0, d: 32'h0});
        if (ec && cw) ref_mem[ca[7:0]] = cd;
        if (eh && hw) ref_mem[ha[7:0]] = hd;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        c_req = 0; c_wen = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_wen = 0; h_addr = 0; h_wdata = 0;
        @(posedge clk); #1;
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h30, 32'hCAFEF00D);
        preload(8'h40, 32'h0BADF00D);

        // Requests during reset must not produce grants or memory traffic
        c_req = 1; c_addr = 32'h10; h_req = 1; h_wen = 1; h_addr = 32'h44; h_wdata = 32'h55;
        @(negedge clk);
        check("rst_c_gnt", 32'(c_gnt), 32'h0);
        check("rst_h_gnt", 32'(h_gnt), 32'h0);
        check("rst_d_wen", 32'(d_wen), 32'h0);
        check("rst_d_addr", d_addr, 32'h0);
        check("rst_d_wdata", d_wdata, 32'h0);
        check("rst_c_rvalid", 32'(c_rvalid), 32'h0);
        check("rst_h_rvalid", 32'(h_rvalid), 32'h0);
`ifdef DMEM_ARB_STATS_EN
        check("rst_conflict", 32'(conflict_cnt), 32'h0);
`endif
        @(posedge clk); #1;
        c_req = 0; h_req = 0; h_wen = 0;
        rst = 1'b0;
        expq.delete();

        // Core-only read, host-only write then core readback
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        idle();
        step(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, 0, 1);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Core read then host read on consecutive cycles
        step(1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 1);
        idle();

        // Continuous contention: host wins every 5th cycle
        for (int i = 0; i < 10; i++)
            step(1, 0, 32'h10, 0, 1, 0, 32'h30, 0, (i % 5) != 4, (i % 5) == 4);
        idle();

        // Host dropping its request clears the accumulated wait
        step(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 1, 0);
        step(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 1, 0);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 32'h50 + 32'(i), 32'hA0 + 32'(i), 1, 0, 32'h40, 0, i != 4, i == 4);
        idle();

        // Reset right after a core read grant discards the return
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1; c_req = 0;
        @(negedge clk);
        check("rstmid_c_rvalid", 32'(c_rvalid), 32'h0);
        check("rstmid_c_rdata", c_rdata, 32'h0);
        check("rstmid_h_rvalid", 32'(h_rvalid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        expq.delete();
`ifdef DMEM_ARB_STATS_EN
        check("conflict_zero", 32'(conflict_cnt), 32'h0);
`endif
        for (int i = 0; i < 3; i++)
            step(1, 0, 32'h30, 0, 1, 0, 32'h10, 0, 1, 0);
`ifdef DMEM_ARB_STATS_EN
        check("conflict_three", 32'(conflict_cnt), 32'h3);
`endif
        idle();

        // Fresh state after reset: full four-cycle wait again
        for (int i = 0; i < 5; i++)
            step(1, 0, 32'h20, 0, 1, 0, 32'h40, 0, i != 4, i == 4);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the processor core and a host/debug requester (pattern loader, result dump, DMA). Each cycle it issues at most one access to the memory and routes read data back to the requester that issued it. The core has priority. A bounded-wait rule guarantees host progress. The block sits between `core`/host logic and `data_mem`, replacing the direct core-to-memory connection.

## Interface
- `ADDR_W`, default 32: address width on all ports.
- `DATA_W`, default 32: data width on all ports.
- `HOST_MAX_WAIT`, default 4: consecutive denied host-request cycles after which the host is forced to win; legal range 1..255.

Clock and reset:
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.

Core side:
- `i_c_req` in 1: core access request.
- `i_c_wen` in 1: 1 = write, 0 = read.
- `i_c_addr` in ADDR_W: core address.
- `i_c_wdata` in DATA_W: core write data.
- `o_c_gnt` out 1: core access issued this cycle.
- `o_c_rvalid` out 1: core read data valid.
- `o_c_rdata` out DATA_W: core read data.

Host side:
- `i_h_req`, `i_h_wen`, `i_h_addr`, `i_h_wdata`, `o_h_gnt`, `o_h_rvalid`, `o_h_rdata`: same widths and meanings as the core-side ports, for the host.

Memory side:
- `o_d_wen` out 1: memory write enable.
- `o_d_addr` out ADDR_W: memory address.
- `o_d_wdata` out DATA_W: memory write data.
- `i_d_rdata` in DATA_W: memory read data, valid the cycle after the read address is presented.

## Operation
- Requester rule: a requester holds `req`, `wen`, `addr` and `wdata` stable until it sees `gnt` high at a rising edge. It may drop `req` the cycle after `gnt`.
- Arbitration is combinational within the cycle. The winner's `wen`, `addr` and `wdata` drive `o_d_*`, and the winner's `gnt` is high.
- With no winner: `o_d_wen`=0, `o_d_addr`=0, `o_d_wdata`=0.
- State machine, two states:
  - **CORE_PRI** (reset state): core wins if `i_c_req`; otherwise host wins if `i_h_req`.
  - **HOST_FORCE**: host wins if `i_h_req`, even when the core requests; otherwise core wins if `i_c_req`.
- Wait counter (8-bit):
  - Cleared on any host grant, and whenever `i_h_req`=0.
  - Incremented on each cycle with `i_h_req`=1 and no host grant.
  - Transition CORE_PRI→HOST_FORCE when the counter reaches `HOST_MAX_WAIT`.
  - Transition HOST_FORCE→CORE_PRI after a host grant, or when `i_h_req` drops.
- Read return:
  - A one-bit owner tag and a valid flag are registered on every read grant.
  - The next cycle, the owner's `rvalid`=1 and its `rdata`=`i_d_rdata`. The non-owner's `rdata`=0.
  - Writes produce no `rvalid`.
- Back-to-back grants to the same or different requesters are allowed every cycle. A read return in cycle N+1 coexists with a new grant in cycle N+1.
- The block has no write-to-read forwarding. Memory ordering is the issue order.

## Timing
- Grant latency: 0 cycles when uncontested (`gnt` in the same cycle as `req`). Worst-case host latency is `HOST_MAX_WAIT`+1 cycles under continuous core requests.
- Read data: exactly 1 cycle after the grant.
- Reset values:
  - `o_c_gnt`, `o_h_gnt`, `o_c_rvalid`, `o_h_rvalid` = 0.
  - `o_c_rdata`, `o_h_rdata`, `o_d_*` = 0.
  - State = CORE_PRI; counter = 0.
- Reset asserted mid-operation: a pending read return is discarded and no `rvalid` follows. Outputs go to their reset values asynchronously.
- Simultaneous request in CORE_PRI with counter < `HOST_MAX_WAIT`: core wins and the counter increments.
- Counter saturates at `HOST_MAX_WAIT` and never wraps.

## Configuration
- `DMEM_ARB_STATS_EN`:
  - Defined: adds output `o_conflict_cnt` (16-bit). It increments on each cycle where both `req` inputs are high. It saturates at 16'hFFFF and resets to 0.
  - Undefined: the port and the counter are absent. Arbitration behaviour is identical.

## Test plan
- Core-only read of addr 0x10 (memory word 0xDEADBEEF): `o_c_gnt`=1 in cycle 0, then `o_c_rvalid`=1 and `o_c_rdata`=0xDEADBEEF in cycle 1, with `o_h_rvalid`=0.
- Host-only write of 0x12345678 to addr 0x20: `o_h_gnt`=1, `o_d_wen`=1, `o_d_addr`=0x20 in the same cycle; a later core read of 0x20 returns 0x12345678.
- Both requesting continuously, `HOST_MAX_WAIT`=4: core granted for 4 cycles, host granted in the 5th, then the core resumes. The pattern repeats with period 5.
- Core read in cycle N, host read in cycle N+1: `o_c_rvalid` in N+1 and `o_h_rvalid` in N+2, each carrying its own address's data.
- `i_rst` pulsed the cycle after a core read grant: no `o_c_rvalid`, state CORE_PRI, counter 0. With `DMEM_ARB_STATS_EN`, `o_conflict_cnt`=0, and 3 contested cycles then read 3.
